rd_fwft_stage: RTL and testbench
================================

// Module: rd_fwft_stage
// PURPOSE
//  Read-side output stage of the async FIFO, in the r_clk domain, directly downstream of the read-pointer block.
//  Watches r_empty and issues r_req to fetch words from the dual-port RAM. Absorbs the RAM read latency.
//  Presents words as a first-word-fall-through valid/ready stream (m_valid/m_data/m_ready) at full throughput.
// PARAMETERS
//  WIDTH_D  8  data word width
//  RD_LAT   1  RAM read latency in r_clk cycles, from r_req accepted to r_data valid (legal 1..3)
//  BUF_D    RD_LAT+1  skid entries; derived, never overridden
// PORTS
//  r_clk     in   1        read-domain clock
//  r_rst     in   1        synchronous, active-high reset
//  r_empty   in   1        FIFO empty, from the read-pointer block
//  r_req     out  1        read request; the pointer advances when r_req && !r_empty
//  r_data    in   WIDTH_D  RAM read data, valid RD_LAT cycles after an accepted r_req
//  m_valid   out  1        output word available
//  m_data    out  WIDTH_D  output word (head of the skid buffer)
//  m_ready   in   1        consumer accepts m_data when m_valid && m_ready
//  m_cnt     out  16       words delivered (only with RD_FWFT_CNT_EN)
// BEHAVIOUR
//  Reset values: r_req=0, m_valid=0, m_data=0, m_cnt=0. Reset clears the in-flight pipe, buffer and credits.
//  Reset mid-operation discards words in flight; the FIFO pointer reset is the owner's responsibility.
//  Credit: cred = stored + in_flight, range 0..BUF_D.
//  r_req = !r_empty && (cred < BUF_D || pop). pop = m_valid && m_ready. r_req is combinational.
//  Never r_req when r_empty: no read is issued on an empty FIFO.
//  An accepted r_req pushes a 1 into the RD_LAT-deep valid shift pipe.
//  When the pipe tail is 1, r_data is written to the buffer on that edge.
//  Buffer is a circular BUF_D-entry store with wr_ptr/rd_ptr of clog2(BUF_D) bits that wrap at BUF_D (not power of two).
//  m_valid = stored != 0. m_data = buf[rd_ptr], registered storage, no combinational path from r_data.
//  Same-cycle push and pop: stored unchanged, both pointers advance; cred updates by (+req) - (pop).
//  Throughput: with m_ready held high and FIFO non-empty, 1 word per cycle after RD_LAT+1 cycles of startup latency.
//  First word: r_req asserted at cycle t with r_empty=0 -> m_valid=1 at t+RD_LAT+1.
//  Backpressure: m_ready=0 -> r_req stops once cred==BUF_D. No overflow and no lost words.
//  Overflow and underflow are impossible by construction; an SVA asserts cred <= BUF_D and stored <= BUF_D.
//  m_data must stay stable while m_valid && !m_ready.
// CONFIGURATION
//  Macro RD_FWFT_CNT_EN
//   Defined: m_cnt increments on each pop and wraps 16'hFFFF -> 0. Cleared by r_rst.
//   Undefined: m_cnt is tied to 0 and the counter logic is absent.
//   The port exists in both builds.
// STRUCTURE
//  Shared package fifo_pkg:
//   - FIFO_RD_LAT_MAX = 3
//   - function clog2
//   - typedef for credit width, sized from BUF_D
//  Sub-module rd_skid_buf: the circular store, wr/rd pointers and stored count.
//  Top level: credit logic, latency pipe, counter.
// TESTING
//  1. Reset: hold r_rst=1 3 cycles with r_empty=0 -> r_req=0, m_valid=0, m_cnt=0 throughout.
//  2. Single word, RD_LAT=1: r_empty falls for one accepted read, r_data=8'hA5 at t+1
//     -> m_valid=1 with m_data=A5 at t+2; m_ready=1 -> m_valid=0 next cycle.
//  3. Streaming: 64 words 0..63, m_ready=1 -> r_req high every cycle and m_data 0..63 in order
//     with no gaps after startup; m_cnt=64 (with RD_FWFT_CNT_EN).
//  4. Backpressure: m_ready=0 with the FIFO full -> exactly BUF_D r_req pulses, then r_req=0.
//     Release m_ready -> words arrive in order with no loss or duplication.
//  5. Empty boundary: r_empty toggles every cycle during a stream, m_ready random
//     -> no r_req while r_empty=1, ordering preserved, SVA clean. Repeat for RD_LAT=2 and 3.
//  6. Reset mid-stream with 2 words in flight -> all outputs 0 the cycle after reset and no stale words emitted later.
//     With RD_FWFT_CNT_EN, preload m_cnt to FFFF then one pop -> m_cnt=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: read-latency bound, clog2 helper and the credit/count type.
package fifo_pkg;

  localparam int FIFO_RD_LAT_MAX = 3;

  // Ceiling log2, never below 1 so a 2-entry store still gets a 1-bit pointer.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int FIFO_BUF_D_MAX = FIFO_RD_LAT_MAX + 1;
  localparam int CRED_W         = clog2(FIFO_BUF_D_MAX + 1);

  typedef logic [CRED_W-1:0] cred_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Circular skid store for the read-side FWFT stage; depth need not be a power of two.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH_D = 8,
  parameter int BUF_D   = 2
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic               wr_en,
  input  logic [WIDTH_D-1:0] wr_data,
  input  logic               rd_en,
  output logic [WIDTH_D-1:0] head,
  output cred_t              stored
);

  localparam int PTR_W = clog2(BUF_D);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [WIDTH_D-1:0] mem [BUF_D];

  // Pointers wrap at BUF_D rather than at their natural binary width.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      stored <= '0;
      for (int i = 0; i < BUF_D; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (rd_en) rd_ptr <= bump(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   stored <= stored + 1'b1;
        2'b01:   stored <= stored - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage: credit-based prefetch from the RAM into a skid buffer.
// Optional macro RD_FWFT_CNT_EN enables the 16-bit delivered-word counter on m_cnt.
module rd_fwft_stage
  import fifo_pkg::*;
#(
  parameter int WIDTH_D = 8,
  parameter int RD_LAT  = 1
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic               r_empty,
  output logic               r_req,
  input  logic [WIDTH_D-1:0] r_data,
  output logic               m_valid,
  output logic [WIDTH_D-1:0] m_data,
  input  logic               m_ready,
  output logic [15:0]        m_cnt
);

  localparam int BUF_D = RD_LAT + 1;

  cred_t             cred;
  cred_t             stored;
  logic [RD_LAT-1:0] lat_pipe;
  logic              pop;
  logic              land;

  assign pop  = m_valid && m_ready;
  assign land = lat_pipe[RD_LAT-1];

  // A pop frees a slot on the same edge, so requesting at full credit is still safe.
  assign r_req = !r_rst && !r_empty && ((cred < cred_t'(BUF_D)) || pop);

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      cred     <= '0;
      lat_pipe <= '0;
    end else begin
      lat_pipe <= RD_LAT'({lat_pipe, r_req});
      case ({r_req, pop})
        2'b10:   cred <= cred + 1'b1;
        2'b01:   cred <= cred - 1'b1;
        default: ;
      endcase
    end
  end

  rd_skid_buf #(
    .WIDTH_D (WIDTH_D),
    .BUF_D   (BUF_D)
  ) u_skid (
    .r_clk   (r_clk),
    .r_rst   (r_rst),
    .wr_en   (land),
    .wr_data (r_data),
    .rd_en   (pop),
    .head    (m_data),
    .stored  (stored)
  );

  assign m_valid = (stored != '0);

`ifdef RD_FWFT_CNT_EN
  always_ff @(posedge r_clk) begin
    if (r_rst)    m_cnt <= '0;
    else if (pop) m_cnt <= m_cnt + 16'd1;
  end
`else
  assign m_cnt = '0;
`endif

  a_cred_max:   assert property (@(posedge r_clk) disable iff (r_rst) cred <= cred_t'(BUF_D));
  a_stored_max: assert property (@(posedge r_clk) disable iff (r_rst) stored <= cred_t'(BUF_D));
  a_no_req_mt:  assert property (@(posedge r_clk) r_empty |-> !r_req);
  a_hold:       assert property (@(posedge r_clk) disable iff (r_rst)
                                 (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Bench for rd_fwft_stage: three lanes at RD_LAT=1,2,3 share r_empty/m_ready, each with its own RAM model.
module tb_rd_fwft_stage;

  localparam int NL = 3;
`ifdef RD_FWFT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        r_clk   = 1'b0;
  logic        r_rst   = 1'b1;
  logic        r_empty = 1'b1;
  logic        m_ready = 1'b0;
  logic        r_req   [NL];
  logic        m_valid [NL];
  logic [7:0]  r_data  [NL];
  logic [7:0]  m_data  [NL];
  logic [15:0] m_cnt   [NL];
  logic [7:0]  word_base = 8'h00;
  int          occ       [NL];
  int          delivered [NL];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 r_clk = ~r_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic empty, input logic rdy);
    @(posedge r_clk);
    #1;
    r_rst   = rst;
    r_empty = empty;
    m_ready = rdy;
  endtask

  // Each lane: DUT, latency-accurate RAM model, in-order scoreboard and hold monitor.
  for (genvar g = 0; g < NL; g++) begin : gen_lane
    localparam int L = g + 1;
    logic [7:0] src_cnt = 8'h00;
    logic [7:0] dpipe [L];
    logic [7:0] exp_mem [256];
    int         wr_n = 0;
    int         rd_n = 0;
    logic       hold_chk = 1'b0;
    logic [7:0] held = 8'h00;

    rd_fwft_stage #(.WIDTH_D(8), .RD_LAT(L)) u_dut (
      .r_clk   (r_clk),
      .r_rst   (r_rst),
      .r_empty (r_empty),
      .r_req   (r_req[g]),
      .r_data  (r_data[g]),
      .m_valid (m_valid[g]),
      .m_data  (m_data[g]),
      .m_ready (m_ready),
      .m_cnt   (m_cnt[g])
    );

    assign r_data[g]    = dpipe[L-1];
    assign occ[g]       = wr_n - rd_n;
    assign delivered[g] = rd_n;

    always @(posedge r_clk) begin
      for (int k = L - 1; k > 0; k--) dpipe[k] <= dpipe[k-1];
      dpipe[0] <= 8'(src_cnt + word_base);
      if (r_rst) begin
        wr_n <= 0;
        rd_n <= 0;
      end else begin
        if (r_req[g] && !r_empty) begin
          exp_mem[wr_n[7:0]] <= 8'(src_cnt + word_base);
          wr_n    <= wr_n + 1;
          src_cnt <= src_cnt + 8'd1;
        end
        if (m_valid[g] && m_ready) rd_n <= rd_n + 1;
      end
    end

    always @(negedge r_clk) begin
      if (r_rst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          checkOutput($sformatf("L%0d hold_valid", L), m_valid[g], 1);
          checkOutput($sformatf("L%0d hold_data", L), m_data[g], held);
        end
        if (r_empty) checkOutput($sformatf("L%0d no_req_empty", L), r_req[g], 0);
        if (m_valid[g] && m_ready) begin
          checkOutput($sformatf("L%0d pop_has_word", L), 32'(wr_n > rd_n), 1);
          if (wr_n > rd_n) checkOutput($sformatf("L%0d order", L), m_data[g], exp_mem[rd_n[7:0]]);
        end
        hold_chk = m_valid[g] && !m_ready;
        held     = m_data[g];
      end
    end
  end

  initial begin
    int req_cnt  [NL];
    int del_base [NL];

    // Reset held three cycles with a non-empty FIFO
    r_rst = 1'b1; r_empty = 1'b0; m_ready = 1'b0;
    repeat (3) begin
      @(posedge r_clk);
      @(negedge r_clk);
      for (int g = 0; g < NL; g++) begin
        checkOutput($sformatf("rst L%0d r_req", g + 1), r_req[g], 0);
        checkOutput($sformatf("rst L%0d m_valid", g + 1), m_valid[g], 0);
        checkOutput($sformatf("rst L%0d m_data", g + 1), m_data[g], 0);
        checkOutput($sformatf("rst L%0d m_cnt", g + 1), m_cnt[g], 0);
      end
    end
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);

    // Single word A5 through lane 1
    word_base = 8'hA5;
    applyStimulus(0, 0, 0);
    @(negedge r_clk);
    checkOutput("single r_req", r_req[0], 1);
    applyStimulus(0, 1, 0);
    @(negedge r_clk);
    checkOutput("single early_valid", m_valid[0], 0);
    applyStimulus(0, 1, 1);
    @(negedge r_clk);
    checkOutput("single m_valid", m_valid[0], 1);
    checkOutput("single m_data", m_data[0], 8'hA5);
    applyStimulus(0, 1, 1);
    @(negedge r_clk);
    checkOutput("single drained", m_valid[0], 0);
    checkOutput("single m_cnt", m_cnt[0], CNT_EN ? 1 : 0);
    repeat (4) applyStimulus(0, 1, 1);
    for (int g = 0; g < NL; g++) checkOutput($sformatf("single L%0d occ", g + 1), occ[g], 0);

    // Streaming 64 words 0..63 with m_ready held high
    word_base = 8'hFF;
    for (int c = 0; c < 68; c++) begin
      applyStimulus(0, (c >= 64), 1);
      @(negedge r_clk);
      for (int g = 0; g < NL; g++) begin
        checkOutput($sformatf("stream L%0d r_req c%0d", g + 1, c), r_req[g], (c < 64));
        if (c >= g + 2 && c - g - 2 < 64) begin
          checkOutput($sformatf("stream L%0d valid c%0d", g + 1, c), m_valid[g], 1);
          checkOutput($sformatf("stream L%0d data c%0d", g + 1, c), m_data[g], c - g - 2);
        end
      end
    end
    applyStimulus(0, 1, 1);
    @(negedge r_clk);
    for (int g = 0; g < NL; g++) begin
      checkOutput($sformatf("stream L%0d idle", g + 1), m_valid[g], 0);
      checkOutput($sformatf("stream L%0d m_cnt", g + 1), m_cnt[g], CNT_EN ? 65 : 0);
    end

    // Backpressure: exactly BUF_D requests, then drain with no loss
    for (int g = 0; g < NL; g++) req_cnt[g] = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 0, 0);
      @(negedge r_clk);
      for (int g = 0; g < NL; g++) req_cnt[g] += int'(r_req[g]);
    end
    for (int g = 0; g < NL; g++) begin
      checkOutput($sformatf("bp L%0d req_pulses", g + 1), req_cnt[g], g + 2);
      checkOutput($sformatf("bp L%0d req_stopped", g + 1), r_req[g], 0);
      checkOutput($sformatf("bp L%0d valid", g + 1), m_valid[g], 1);
      del_base[g] = delivered[g];
    end
    repeat (8) applyStimulus(0, 1, 1);
    @(negedge r_clk);
    for (int g = 0; g < NL; g++) begin
      checkOutput($sformatf("bp L%0d drained_cnt", g + 1), delivered[g] - del_base[g], g + 2);
      checkOutput($sformatf("bp L%0d occ", g + 1), occ[g], 0);
    end

    // Empty boundary: r_empty toggles, m_ready random
    for (int c = 0; c < 200; c++) applyStimulus(0, (c % 2 == 1), 1'($urandom_range(0, 1)));
    repeat (10) applyStimulus(0, 1, 1);
    @(negedge r_clk);
    for (int g = 0; g < NL; g++) begin
      checkOutput($sformatf("toggle L%0d occ", g + 1), occ[g], 0);
      checkOutput($sformatf("toggle L%0d idle", g + 1), m_valid[g], 0);
    end

    // Reset mid-stream with two reads in flight on the RD_LAT=3 lane
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    @(negedge r_clk);
    checkOutput("midrst L3 inflight", occ[2], 2);
    applyStimulus(0, 1, 1);
    @(negedge r_clk);
    for (int g = 0; g < NL; g++) begin
      checkOutput($sformatf("midrst L%0d r_req", g + 1), r_req[g], 0);
      checkOutput($sformatf("midrst L%0d m_valid", g + 1), m_valid[g], 0);
      checkOutput($sformatf("midrst L%0d m_data", g + 1), m_data[g], 0);
      checkOutput($sformatf("midrst L%0d m_cnt", g + 1), m_cnt[g], 0);
    end
    repeat (8) begin
      applyStimulus(0, 1, 1);
      @(negedge r_clk);
      for (int g = 0; g < NL; g++) checkOutput($sformatf("midrst L%0d stale", g + 1), m_valid[g], 0);
    end
    repeat (4) applyStimulus(0, 0, 1);
    repeat (8) applyStimulus(0, 1, 1);
    @(negedge r_clk);
    for (int g = 0; g < NL; g++) begin
      checkOutput($sformatf("post L%0d occ", g + 1), occ[g], 0);
      checkOutput($sformatf("post L%0d delivered", g + 1), delivered[g], 4);
      checkOutput($sformatf("post L%0d m_cnt", g + 1), m_cnt[g], CNT_EN ? 4 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: time %0t, expected finish earlier", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
